// File: rtl/axis_fft8_dft_cplx_pkg.sv
// rtl/axis_fft8_dft_cplx_pkg.sv - shared constants and index helpers for the 8-point DFT
package axis_fft8_dft_cplx_pkg;

   localparam int FFT8_N = 8;

   function automatic int fft_c707(input int twid_w);
      return int'(0.70710678 * real'(1 << (twid_w - 1)));
   endfunction

   function automatic int bitrev3(input int n);
      return ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
   endfunction

   // Lane n of a packed complex vector: re in the upper half, im in the lower half.
   function automatic int re_lsb(input int n, input int w);
      return 2 * n * w + w;
   endfunction

   function automatic int im_lsb(input int n, input int w);
      return 2 * n * w;
   endfunction

endpackage

// File: rtl/axis_fft8_dft_cplx_tw_mul.sv
// rtl/axis_fft8_dft_cplx_tw_mul.sv - a +/- round(W8^1 or W8^3 * b), combinational
module axis_fft8_dft_cplx_tw_mul
   import axis_fft8_dft_cplx_pkg::*;
#(
   parameter int IN_W   = 10,
   parameter int RES_W  = 12,
   parameter int TWID_W = 16,
   parameter bit W3SEL  = 1'b0,
   parameter bit SUB    = 1'b0
) (
   input  logic signed [IN_W-1:0]  a_re,
   input  logic signed [IN_W-1:0]  a_im,
   input  logic signed [IN_W-1:0]  b_re,
   input  logic signed [IN_W-1:0]  b_im,
   output logic signed [RES_W-1:0] x_re,
   output logic signed [RES_W-1:0] x_im
);
   localparam int PW = IN_W + TWID_W + 2;
   localparam int C  = fft_c707(TWID_W);
   localparam logic signed [PW-1:0] HALF = PW'(1 << (TWID_W - 2));

   logic signed [IN_W:0]    s, d;
   logic signed [PW-1:0]    p_re, p_im;
   logic signed [RES_W-1:0] r_re, r_im;

   // W8^1 = C(1-j): (C(r+i), C(i-r));  W8^3 = -C(1+j): (C(i-r), -C(r+i))
   assign s    = (IN_W + 1)'(b_re) + (IN_W + 1)'(b_im);
   assign d    = (IN_W + 1)'(b_im) - (IN_W + 1)'(b_re);
   assign p_re = W3SEL ? (PW'(d) * PW'(C)) : (PW'(s) * PW'(C));
   assign p_im = W3SEL ? -(PW'(s) * PW'(C)) : (PW'(d) * PW'(C));

   assign r_re = RES_W'((p_re + HALF) >>> (TWID_W - 1));
   assign r_im = RES_W'((p_im + HALF) >>> (TWID_W - 1));

   assign x_re = SUB ? (RES_W'(a_re) - r_re) : (RES_W'(a_re) + r_re);
   assign x_im = SUB ? (RES_W'(a_im) - r_im) : (RES_W'(a_im) + r_im);

endmodule

// File: rtl/axis_fft8_dft_cplx.sv
// rtl/axis_fft8_dft_cplx.sv - 3-stage pipelined 8-point complex DFT/IDFT over AXI4-Stream
module axis_fft8_dft_cplx
   import axis_fft8_dft_cplx_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int OUT_W     = 32,
   parameter int TWID_W    = 16,
   parameter int TUSER_W   = 1,
   parameter bit SCALE_INV = 1'b1
) (
   input  logic                  s_axis_aclk,
   input  logic                  s_axis_aresetn,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic [16*DATA_W-1:0]  s_axis_tdata,
   input  logic                  s_axis_tlast,
   input  logic [TUSER_W-1:0]    s_axis_tuser,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic [16*OUT_W-1:0]   m_axis_tdata,
   output logic                  m_axis_tlast,
   output logic [TUSER_W-1:0]    m_axis_tuser
);
   localparam int W1 = DATA_W + 1;
   localparam int W2 = DATA_W + 2;
   // Stage 3 keeps one guard bit: complex inputs through diagonal twiddles grow by sqrt(2).
   localparam int W3 = DATA_W + 4;

   if (OUT_W < DATA_W + 4) begin : g_width_check
      $error("axis_fft8_dft_cplx: OUT_W must be >= DATA_W+4");
   end

   logic en;
   assign en            = ~m_axis_tvalid | m_axis_tready;
   assign s_axis_tready = en;

   logic signed [DATA_W-1:0] a_re [FFT8_N], a_im [FFT8_N];
   logic signed [W1-1:0]     y_re_d [FFT8_N], y_im_d [FFT8_N], y_re [FFT8_N], y_im [FFT8_N];
   logic signed [W2-1:0]     z_re_d [FFT8_N], z_im_d [FFT8_N], z_re [FFT8_N], z_im [FFT8_N];
   logic signed [W3-1:0]     x_re [FFT8_N], x_im [FFT8_N];
   logic [16*OUT_W-1:0]      tdata_d;
   logic                     v1, l1, v2, l2, inv;
   logic [TUSER_W-1:0]       u1, u2;

   // Inverse mode: IDFT(x) = swap(DFT(swap(x))); input swap happens here.
   for (genvar n = 0; n < FFT8_N; n++) begin : g_in
      localparam int SRC = bitrev3(n);
      logic signed [DATA_W-1:0] raw_re, raw_im;
      assign raw_re  = s_axis_tdata[re_lsb(SRC, DATA_W) +: DATA_W];
      assign raw_im  = s_axis_tdata[im_lsb(SRC, DATA_W) +: DATA_W];
      assign a_re[n] = s_axis_tuser[0] ? raw_im : raw_re;
      assign a_im[n] = s_axis_tuser[0] ? raw_re : raw_im;
   end

   for (genvar m = 0; m < 4; m++) begin : g_s1
      assign y_re_d[2*m]   = W1'(a_re[2*m]) + W1'(a_re[2*m+1]);
      assign y_im_d[2*m]   = W1'(a_im[2*m]) + W1'(a_im[2*m+1]);
      assign y_re_d[2*m+1] = W1'(a_re[2*m]) - W1'(a_re[2*m+1]);
      assign y_im_d[2*m+1] = W1'(a_im[2*m]) - W1'(a_im[2*m+1]);
   end

   for (genvar g = 0; g < 2; g++) begin : g_s2
      localparam int B = 4 * g;
      assign z_re_d[B]   = W2'(y_re[B]) + W2'(y_re[B+2]);
      assign z_im_d[B]   = W2'(y_im[B]) + W2'(y_im[B+2]);
      assign z_re_d[B+2] = W2'(y_re[B]) - W2'(y_re[B+2]);
      assign z_im_d[B+2] = W2'(y_im[B]) - W2'(y_im[B+2]);
      // -j * (r + ji) = i - jr
      assign z_re_d[B+1] = W2'(y_re[B+1]) + W2'(y_im[B+3]);
      assign z_im_d[B+1] = W2'(y_im[B+1]) - W2'(y_re[B+3]);
      assign z_re_d[B+3] = W2'(y_re[B+1]) - W2'(y_im[B+3]);
      assign z_im_d[B+3] = W2'(y_im[B+1]) + W2'(y_re[B+3]);
   end

   assign x_re[0] = W3'(z_re[0]) + W3'(z_re[4]);
   assign x_im[0] = W3'(z_im[0]) + W3'(z_im[4]);
   assign x_re[4] = W3'(z_re[0]) - W3'(z_re[4]);
   assign x_im[4] = W3'(z_im[0]) - W3'(z_im[4]);
   assign x_re[2] = W3'(z_re[2]) + W3'(z_im[6]);
   assign x_im[2] = W3'(z_im[2]) - W3'(z_re[6]);
   assign x_re[6] = W3'(z_re[2]) - W3'(z_im[6]);
   assign x_im[6] = W3'(z_im[2]) + W3'(z_re[6]);

   axis_fft8_dft_cplx_tw_mul #(.IN_W(W2), .RES_W(W3), .TWID_W(TWID_W), .W3SEL(1'b0), .SUB(1'b0)) u_tw1 (
      .a_re(z_re[1]), .a_im(z_im[1]), .b_re(z_re[5]), .b_im(z_im[5]), .x_re(x_re[1]), .x_im(x_im[1]));
   axis_fft8_dft_cplx_tw_mul #(.IN_W(W2), .RES_W(W3), .TWID_W(TWID_W), .W3SEL(1'b0), .SUB(1'b1)) u_tw5 (
      .a_re(z_re[1]), .a_im(z_im[1]), .b_re(z_re[5]), .b_im(z_im[5]), .x_re(x_re[5]), .x_im(x_im[5]));
   axis_fft8_dft_cplx_tw_mul #(.IN_W(W2), .RES_W(W3), .TWID_W(TWID_W), .W3SEL(1'b1), .SUB(1'b0)) u_tw3 (
      .a_re(z_re[3]), .a_im(z_im[3]), .b_re(z_re[7]), .b_im(z_im[7]), .x_re(x_re[3]), .x_im(x_im[3]));
   axis_fft8_dft_cplx_tw_mul #(.IN_W(W2), .RES_W(W3), .TWID_W(TWID_W), .W3SEL(1'b1), .SUB(1'b1)) u_tw7 (
      .a_re(z_re[3]), .a_im(z_im[3]), .b_re(z_re[7]), .b_im(z_im[7]), .x_re(x_re[7]), .x_im(x_im[7]));

   assign inv = u2[0];

   for (genvar k = 0; k < FFT8_N; k++) begin : g_out
      logic signed [W3-1:0] o_re, o_im, s_re, s_im;
      assign o_re = inv ? x_im[k] : x_re[k];
      assign o_im = inv ? x_re[k] : x_im[k];
      assign s_re = (SCALE_INV && inv) ? (o_re >>> 3) : o_re;
      assign s_im = (SCALE_INV && inv) ? (o_im >>> 3) : o_im;
      assign tdata_d[re_lsb(k, OUT_W) +: OUT_W] = OUT_W'(s_re);
      assign tdata_d[im_lsb(k, OUT_W) +: OUT_W] = OUT_W'(s_im);
   end

   always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
      if (!s_axis_aresetn) begin
         v1            <= 1'b0;
         l1            <= 1'b0;
         u1            <= '0;
         y_re          <= '{default: '0};
         y_im          <= '{default: '0};
         v2            <= 1'b0;
         l2            <= 1'b0;
         u2            <= '0;
         z_re          <= '{default: '0};
         z_im          <= '{default: '0};
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         m_axis_tuser  <= '0;
         m_axis_tdata  <= '0;
      end else if (en) begin
         v1            <= s_axis_tvalid;
         l1            <= s_axis_tlast;
         u1            <= s_axis_tuser;
         y_re          <= y_re_d;
         y_im          <= y_im_d;
         v2            <= v1;
         l2            <= l1;
         u2            <= u1;
         z_re          <= z_re_d;
         z_im          <= z_im_d;
         m_axis_tvalid <= v2;
         m_axis_tlast  <= l2;
         m_axis_tuser  <= u2;
         m_axis_tdata  <= tdata_d;
      end
   end

endmodule

// File: tb/tb_axis_fft8_dft_cplx.sv
// tb/tb_axis_fft8_dft_cplx.sv - directed self-checking bench for axis_fft8_dft_cplx
module tb_axis_fft8_dft_cplx;
   localparam int DW = 8;
   localparam int OW = 32;
   localparam int UW = 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              s_valid, s_ready, s_last, m_valid, m_ready, m_last;
   logic [16*DW-1:0]  s_data;
   logic [16*OW-1:0]  m_data, prev;
   logic [UW-1:0]     s_user, m_user;
   logic signed [DW-1:0] xr [8], xi [8];
   int                n_assert = 0;
   int                n_fail = 0;
   int                sent, got;
   logic              have_prev;

   always #5 clk = ~clk;

   axis_fft8_dft_cplx #(.DATA_W(DW), .OUT_W(OW), .TWID_W(16), .TUSER_W(UW), .SCALE_INV(1'b1)) dut (
      .s_axis_aclk(clk), .s_axis_aresetn(rst_n),
      .s_axis_tvalid(s_valid), .s_axis_tready(s_ready), .s_axis_tdata(s_data),
      .s_axis_tlast(s_last), .s_axis_tuser(s_user),
      .m_axis_tvalid(m_valid), .m_axis_tready(m_ready), .m_axis_tdata(m_data),
      .m_axis_tlast(m_last), .m_axis_tuser(m_user));

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic signed [63:0] bre(input int k);
      logic signed [OW-1:0] v;
      v = m_data[2*k*OW+OW +: OW];
      return 64'(v);
   endfunction

   function automatic logic signed [63:0] bim(input int k);
      logic signed [OW-1:0] v;
      v = m_data[2*k*OW +: OW];
      return 64'(v);
   endfunction

   task automatic clear_x();
      for (int n = 0; n < 8; n++) begin
         xr[n] = '0;
         xi[n] = '0;
      end
   endtask

   task automatic pack_x();
      for (int n = 0; n < 8; n++) begin
         s_data[2*n*DW+DW +: DW] = xr[n];
         s_data[2*n*DW +: DW]    = xi[n];
      end
   endtask

   // One isolated beat; returns at the negedge where its result is on the output.
   task automatic run_one(input string tag, input logic user, input logic last);
      @(negedge clk);
      pack_x();
      s_user  = user;
      s_last  = last;
      s_valid = 1'b1;
      m_ready = 1'b1;
      #1 chk({tag, "_s_ready"}, s_ready, 1);
      @(negedge clk);
      s_valid = 1'b0;
      chk({tag, "_valid_c1"}, m_valid, 0);
      @(negedge clk);
      chk({tag, "_valid_c2"}, m_valid, 0);
      @(negedge clk);
      chk({tag, "_valid_c3"}, m_valid, 1);
      chk({tag, "_tlast"}, m_last, 64'(last));
      chk({tag, "_tuser"}, m_user, 64'(user));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      s_valid = 1'b0; s_last = 1'b0; s_user = '0; s_data = '0; m_ready = 1'b1;
      clear_x();
      repeat (2) @(negedge clk);
      chk("rst_tvalid", m_valid, 0);
      chk("rst_tdata", m_data === '0, 1);
      chk("rst_tlast", m_last, 0);
      chk("rst_tuser", m_user, 0);
      chk("rst_s_ready", s_ready, 1);
      rst_n = 1'b1;

      clear_x(); xr[0] = 64;
      run_one("imp", 1'b0, 1'b1);
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("imp_re%0d", k), bre(k), 64);
         chk($sformatf("imp_im%0d", k), bim(k), 0);
      end

      clear_x();
      for (int n = 0; n < 8; n++) xr[n] = 16;
      run_one("dc16", 1'b0, 1'b0);
      chk("dc16_re0", bre(0), 128);
      chk("dc16_im0", bim(0), 0);
      for (int k = 1; k < 8; k++) begin
         chk($sformatf("dc16_re%0d", k), bre(k), 0);
         chk($sformatf("dc16_im%0d", k), bim(k), 0);
      end

      clear_x();
      for (int n = 0; n < 8; n++) xr[n] = -128;
      run_one("dcneg", 1'b0, 1'b0);
      chk("dcneg_re0", bre(0), -1024);
      chk("dcneg_im0", bim(0), 0);
      chk("dcneg_re4", bre(4), 0);

      clear_x(); xr[1] = 64;
      run_one("sh", 1'b0, 1'b0);
      chk("sh_re0", bre(0), 64);   chk("sh_im0", bim(0), 0);
      chk("sh_re1", bre(1), 45);   chk("sh_im1", bim(1), -45);
      chk("sh_re2", bre(2), 0);    chk("sh_im2", bim(2), -64);
      chk("sh_re3", bre(3), -45);  chk("sh_im3", bim(3), -45);
      chk("sh_re4", bre(4), -64);  chk("sh_im4", bim(4), 0);
      chk("sh_re5", bre(5), -45);  chk("sh_im5", bim(5), 45);
      chk("sh_re6", bre(6), 0);    chk("sh_im6", bim(6), 64);
      chk("sh_re7", bre(7), 45);   chk("sh_im7", bim(7), 45);

      clear_x(); xr[0] = 64;
      run_one("iimp", 1'b1, 1'b0);
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("iimp_re%0d", k), bre(k), 8);
         chk($sformatf("iimp_im%0d", k), bim(k), 0);
      end

      clear_x(); xr[1] = 64;
      run_one("ish", 1'b1, 1'b1);
      chk("ish_re0", bre(0), 8);  chk("ish_im0", bim(0), 0);
      chk("ish_re1", bre(1), 5);  chk("ish_im1", bim(1), 5);
      chk("ish_re2", bre(2), 0);  chk("ish_im2", bim(2), 8);
      chk("ish_re3", bre(3), -6); chk("ish_im3", bim(3), 5);

      // Back-to-back forward / inverse / forward on the same shifted impulse
      @(negedge clk);
      clear_x(); xr[1] = 64; pack_x();
      s_user = 1'b0; s_last = 1'b0; s_valid = 1'b1; m_ready = 1'b1;
      @(negedge clk); s_user = 1'b1;
      @(negedge clk); s_user = 1'b0;
      @(negedge clk); s_valid = 1'b0;
      chk("mix0_valid", m_valid, 1); chk("mix0_tuser", m_user, 0);
      chk("mix0_re1", bre(1), 45);   chk("mix0_im1", bim(1), -45);
      @(negedge clk);
      chk("mix1_valid", m_valid, 1); chk("mix1_tuser", m_user, 1);
      chk("mix1_re1", bre(1), 5);    chk("mix1_im1", bim(1), 5);
      @(negedge clk);
      chk("mix2_valid", m_valid, 1); chk("mix2_tuser", m_user, 0);
      chk("mix2_re1", bre(1), 45);   chk("mix2_im1", bim(1), -45);

      // Six beats with a 5-cycle downstream stall in the middle
      sent = 0; got = 0; have_prev = 1'b0;
      for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
         @(negedge clk);
         m_ready = !(cyc >= 4 && cyc < 9);
         if (sent < 6) begin
            clear_x(); xr[0] = 8'(10 * sent + 1); xi[0] = 8'(-sent); pack_x();
            s_last = (sent == 5); s_user = 1'b0; s_valid = 1'b1;
         end else begin
            s_valid = 1'b0;
         end
         #1;
         if (m_valid && !m_ready) begin
            chk("bp_stall_s_ready", s_ready, 0);
            if (have_prev) chk("bp_stall_stable", m_data === prev, 1);
            prev = m_data;
            have_prev = 1'b1;
         end else begin
            have_prev = 1'b0;
         end
         if (m_valid && m_ready) begin
            chk($sformatf("bp%0d_re0", got), bre(0), 10 * got + 1);
            chk($sformatf("bp%0d_im0", got), bim(0), -got);
            chk($sformatf("bp%0d_re6", got), bre(6), 10 * got + 1);
            chk($sformatf("bp%0d_tlast", got), m_last, 64'(got == 5));
            got++;
         end
         if (s_valid && s_ready) sent++;
      end
      chk("bp_count", got, 6);
      chk("bp_sent", sent, 6);
      @(negedge clk);
      s_valid = 1'b0;
      chk("bp_no_dup", m_valid, 0);

      // Reset with three beats in flight
      @(negedge clk);
      clear_x(); xr[0] = 5; pack_x();
      s_user = 1'b1; s_last = 1'b1; s_valid = 1'b1; m_ready = 1'b1;
      @(negedge clk); xr[0] = 6; pack_x();
      @(negedge clk); xr[0] = 9; pack_x();
      @(negedge clk); s_valid = 1'b0;
      chk("pre_rst_valid", m_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_tvalid", m_valid, 0);
      chk("arst_tdata", m_data === '0, 1);
      chk("arst_tlast", m_last, 0);
      chk("arst_tuser", m_user, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk($sformatf("post_rst_idle%0d", i), m_valid, 0);
      end
      clear_x(); xr[0] = 7; xi[0] = 3;
      run_one("post", 1'b0, 1'b0);
      chk("post_re0", bre(0), 7); chk("post_im0", bim(0), 3);
      chk("post_re4", bre(4), 7); chk("post_im4", bim(4), 3);
      @(negedge clk);
      chk("post_single", m_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
